// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Bundles the byte-stream handshakes around the shared UART transmitter.
//   req0_*      : CPU MMIO byte stream (data/valid in, ready out)
//   req1_*      : debug/status streamer byte stream (data/valid in, ready out)
//   tx_*        : byte stream into uart_transmitter (data/valid out, ready in)
//   grant       : one-hot current owner, 2'b00 when nobody owns the transmitter
//   lock_active : high while an owner holds the transmitter
// The slave modport is the arbiter's view; the master modport is the
// surrounding logic (requesters plus transmitter) that drives it.
interface uart_tx_arbiter_if;
  logic [7:0] req0_data;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req1_data;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] grant;
  logic       lock_active;

  modport slave (
    input  req0_data, req0_valid, req1_data, req1_valid, tx_ready,
    output req0_ready, req1_ready, tx_data, tx_valid, grant, lock_active
  );

  modport master (
    output req0_data, req0_valid, req1_data, req1_valid, tx_ready,
    input  req0_ready, req1_ready, tx_data, tx_valid, grant, lock_active
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_transmitter between two byte-stream requesters using
// round-robin arbitration with a packet lock. Once a requester wins it keeps
// the transmitter until it sends EOL_BYTE, or until it leaves valid low for
// LOCK_TIMEOUT consecutive cycles, so lines from the two sources never
// interleave. The data path is a pure combinational pass-through of the
// owner's stream; no bytes are buffered here.
// Ports:
//   clk   : cpu_clk
//   rst_n : asynchronous active-low reset
//   bus   : uart_tx_arbiter_if.slave (requester, transmitter and status signals)
// Parameters:
//   EOL_BYTE     : byte that ends a packet and releases the lock
//   LOCK_TIMEOUT : owner-idle cycles before forced release, 0 disables it
module uart_tx_arbiter #(
  parameter logic [7:0]  EOL_BYTE     = 8'h0A,
  parameter int unsigned LOCK_TIMEOUT = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   bus
);

  // A zero timeout would give a zero-width counter, so keep at least one bit.
  localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam bit TIMEOUT_EN = (LOCK_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    TIMEOUT_EN ? CNT_W'(LOCK_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_e;

  state_e           state_q;
  logic             lastWinner_q;
  logic [CNT_W-1:0] idleCnt_q;

  logic       ownValid;
  logic [7:0] ownData;
  logic       handshake;
  logic       timeoutHit;

  // The current owner's stream is selected straight through to the
  // transmitter; in IDLE nothing is offered and data is forced to zero.
  assign ownValid = (state_q == OWN0) ? bus.req0_valid :
                    (state_q == OWN1) ? bus.req1_valid : 1'b0;
  assign ownData  = (state_q == OWN0) ? bus.req0_data  :
                    (state_q == OWN1) ? bus.req1_data  : 8'h00;

  assign bus.tx_valid    = ownValid;
  assign bus.tx_data     = ownData;
  assign bus.req0_ready  = (state_q == OWN0) & bus.tx_ready;
  assign bus.req1_ready  = (state_q == OWN1) & bus.tx_ready;
  assign bus.grant       = {state_q == OWN1, state_q == OWN0};
  assign bus.lock_active = (state_q != IDLE);

  // Backpressure is not idleness: only a low owner valid can reach the
  // timeout, and a handshake always takes priority over it.
  assign handshake  = ownValid & bus.tx_ready;
  assign timeoutHit = TIMEOUT_EN & ~ownValid & (idleCnt_q == CNT_LAST);

  // Ownership FSM. lastWinner_q records who released most recently so a tie
  // in IDLE goes to the other requester; it resets to 1 so req0 wins the
  // first tie. The decision takes one cycle in IDLE and no byte moves then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lastWinner_q <= 1'b1;
      idleCnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          idleCnt_q <= '0;
          if (bus.req0_valid && (!bus.req1_valid || lastWinner_q)) begin
            state_q <= OWN0;
          end else if (bus.req1_valid) begin
            state_q <= OWN1;
          end
        end
        OWN0, OWN1: begin
          if (handshake) begin
            idleCnt_q <= '0;
            if (ownData == EOL_BYTE) begin
              state_q      <= IDLE;
              lastWinner_q <= (state_q == OWN1);
            end
          end else if (ownValid) begin
            idleCnt_q <= '0;
          end else if (timeoutHit) begin
            state_q      <= IDLE;
            lastWinner_q <= (state_q == OWN1);
            idleCnt_q    <= '0;
          end else if (idleCnt_q != CNT_MAX) begin
            idleCnt_q <= idleCnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
